// File: rtl/ga_pkg.sv
// Shared types and default timing for the CPC gate-array sync/interrupt stage.
package ga_pkg;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_WAIT = 2'd1,
    V_ACT  = 2'd2
  } vstate_e;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_e;

  localparam logic [3:0] HS_DELAY     = 4'd2;
  localparam logic [3:0] HS_WIDTH     = 4'd4;
  localparam logic [3:0] HS_END       = HS_DELAY + HS_WIDTH;
  localparam logic [3:0] VS_DELAY     = 4'd2;
  localparam logic [3:0] VS_WIDTH     = 4'd4;
  localparam logic [5:0] IRQ_LINES    = 6'd52;
  localparam logic [5:0] IRQ_LAST     = IRQ_LINES - 6'd1;
  // HSYNC falls after a VSYNC rise at which R52 is resynchronised.
  localparam logic [1:0] RESYNC_FALLS = 2'd2;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/ga_edge_det.sv
// Registered rise/fall detector; edges are reported only on CLKEN cycles.
module ga_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clken_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // Reset loads the live level so a sync already high at reset is not seen as a new edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clken_i) sig_q <= sig_i;
  end

  assign rise_o = clken_i &  sig_i & ~sig_q;
  assign fall_o = clken_i & ~sig_i &  sig_q;

endmodule

// File: rtl/ga_sync_irq.sv
// CPC gate-array sync and raster-interrupt stage downstream of the 6845 CRTC.
// Define CPC_PLUS_PRI_EN for the CPC+ programmable raster interrupt (PRI_LINE/PRI_HIT).
module ga_sync_irq
  import ga_pkg::*;
(
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       CRTC_HSYNC,
  input  logic       CRTC_VSYNC,
  input  logic       INT_ACK,
  input  logic       IRQ_CLR,
  input  logic       MODE_WR,
  input  logic [1:0] MODE_IN,
`ifdef CPC_PLUS_PRI_EN
  input  logic [7:0] PRI_LINE,
  output logic       PRI_HIT,
`endif
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       INT_N,
  output logic [1:0] MODE,
  output logic [5:0] IRQ_CNT
);

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  ga_edge_det u_hs_edge (
    .clk_i(CLOCK), .rst_n_i(nRESET), .clken_i(CLKEN),
    .sig_i(CRTC_HSYNC), .rise_o(hs_rise), .fall_o(hs_fall)
  );

  ga_edge_det u_vs_edge (
    .clk_i(CLOCK), .rst_n_i(nRESET), .clken_i(CLKEN),
    .sig_i(CRTC_VSYNC), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  logic [3:0] hcnt_q, hcnt_d;
  logic       hs_out_q, hs_out_d;
  mode_e      mode_q, mode_d, pend_q, pend_d;

  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_rise) hcnt_d = '0;
    else if (CLKEN && CRTC_HSYNC) hcnt_d = sat_inc4(hcnt_q);
    hs_out_d = hs_out_q;
    if (CLKEN) hs_out_d = CRTC_HSYNC && (hcnt_d >= HS_DELAY) && (hcnt_d < HS_END);
    // A write landing on the rise cycle only reaches MODE at the following HSYNC.
    pend_d = MODE_WR ? mode_e'(MODE_IN) : pend_q;
    mode_d = hs_rise ? pend_q : mode_q;
  end

  vstate_e    v_state_q, v_state_d;
  logic [3:0] vcnt_q, vcnt_d;

  always_ff @(posedge CLOCK) begin
    if (!nRESET) v_state_q <= V_IDLE;
    else         v_state_q <= v_state_d;
  end

  always_comb begin
    v_state_d = v_state_q;
    vcnt_d    = vcnt_q;
    case (v_state_q)
      V_IDLE: begin
        if (vs_rise) begin
          v_state_d = V_WAIT;
          vcnt_d    = '0;
        end
      end
      V_WAIT: begin
        if (vs_fall) begin
          v_state_d = V_IDLE;
          vcnt_d    = '0;
        end else if (hs_fall) begin
          if (sat_inc4(vcnt_q) == VS_DELAY) begin
            v_state_d = V_ACT;
            vcnt_d    = '0;
          end else begin
            vcnt_d = sat_inc4(vcnt_q);
          end
        end
      end
      V_ACT: begin
        if (vs_fall || (hs_fall && sat_inc4(vcnt_q) == VS_WIDTH)) begin
          v_state_d = V_IDLE;
          vcnt_d    = '0;
        end else if (hs_fall) begin
          vcnt_d = sat_inc4(vcnt_q);
        end
      end
      default: begin
        v_state_d = V_IDLE;
        vcnt_d    = '0;
      end
    endcase
  end

  logic [1:0] rs_q, rs_d;
  logic       resync;

  // Counts down the HSYNC falls left until the R52 resync point after a VSYNC rise.
  always_comb begin
    rs_d = rs_q;
    if (vs_rise) rs_d = RESYNC_FALLS;
    else if (hs_fall && rs_q != 2'd0) rs_d = rs_q - 2'd1;
  end
  assign resync = hs_fall && !vs_rise && (rs_q == 2'd1);

  logic       r52_en, pri_fire;
  logic [5:0] cnt_q, cnt_d;
  logic       irq_q, irq_d;

`ifdef CPC_PLUS_PRI_EN
  logic [7:0] line_q, line_d;
  logic       pri_hit_q;

  always_comb begin
    line_d = line_q;
    if (hs_fall) line_d = resync ? 8'd0 : line_q + 8'd1;
  end
  assign pri_fire = hs_fall && (PRI_LINE != 8'd0) && (line_d == PRI_LINE);
  assign r52_en   = (PRI_LINE == 8'd0);

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      line_q    <= '0;
      pri_hit_q <= 1'b0;
    end else begin
      line_q <= line_d;
      if (CLKEN) pri_hit_q <= pri_fire;
    end
  end
  assign PRI_HIT = pri_hit_q;
`else
  assign pri_fire = 1'b0;
  assign r52_en   = 1'b1;
`endif

  // Ack is applied before the line step so a fresh interrupt can re-assert; CLR overrides all.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (INT_ACK) begin
      irq_d    = 1'b0;
      cnt_d[5] = 1'b0;
    end
    if (hs_fall) begin
      if (resync) begin
        if (cnt_d[5] && r52_en) irq_d = 1'b1;
        cnt_d = '0;
      end else if (cnt_d == IRQ_LAST) begin
        cnt_d = '0;
        if (r52_en) irq_d = 1'b1;
      end else begin
        cnt_d = cnt_d + 6'd1;
      end
    end
    if (pri_fire) irq_d = 1'b1;
    if (IRQ_CLR) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      hcnt_q   <= '0;
      hs_out_q <= 1'b0;
      mode_q   <= MODE_0;
      pend_q   <= MODE_0;
      vcnt_q   <= '0;
      rs_q     <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      hs_out_q <= hs_out_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      vcnt_q   <= vcnt_d;
      rs_q     <= rs_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
    end
  end

  assign HSYNC_O = hs_out_q;
  assign VSYNC_O = (v_state_q == V_ACT);
  assign INT_N   = ~irq_q;
  assign MODE    = mode_q;
  assign IRQ_CNT = cnt_q;

endmodule

// File: tb/tb_ga_sync_irq.sv
// Bench for ga_sync_irq: directed scenarios plus randomized lines against a frame-level model.
module tb_ga_sync_irq;

  logic       CLOCK = 1'b0;
  logic       nRESET, CLKEN, CRTC_HSYNC, CRTC_VSYNC, INT_ACK, IRQ_CLR, MODE_WR;
  logic [1:0] MODE_IN, MODE;
  logic       HSYNC_O, VSYNC_O, INT_N;
  logic [5:0] IRQ_CNT;
`ifdef CPC_PLUS_PRI_EN
  logic [7:0] PRI_LINE = 8'd0;
  logic       PRI_HIT;
`endif

  always #5 CLOCK = ~CLOCK;

  ga_sync_irq dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
    .CRTC_HSYNC(CRTC_HSYNC), .CRTC_VSYNC(CRTC_VSYNC),
    .INT_ACK(INT_ACK), .IRQ_CLR(IRQ_CLR), .MODE_WR(MODE_WR), .MODE_IN(MODE_IN),
`ifdef CPC_PLUS_PRI_EN
    .PRI_LINE(PRI_LINE), .PRI_HIT(PRI_HIT),
`endif
    .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O), .INT_N(INT_N), .MODE(MODE), .IRQ_CNT(IRQ_CNT)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: chars since HSYNC rise, HSYNC falls since VSYNC rise, integer R52 count.
  logic       m_hs_prev, m_vs_prev, m_hso, m_valive, m_irq;
  int         m_age, m_fsr, m_cnt;
  logic [1:0] m_mode, m_pend;
  logic [10:0] exp_q[$];

  task automatic model(input logic ce, hs, vs, ack, clr, wr, input logic [1:0] md);
    logic hr, hf, vr, rsy;
    if (!nRESET) begin
      m_hs_prev = hs;  m_vs_prev = vs;
      m_age = 1;  // hcnt restarts at 0 as if a rise had just been seen
      m_fsr = 99; m_valive = 1'b0; m_hso = 1'b0;
      m_cnt = 0;  m_irq = 1'b0; m_mode = 2'd0; m_pend = 2'd0;
    end else begin
      hr  = ce & hs & ~m_hs_prev;
      hf  = ce & ~hs & m_hs_prev;
      vr  = ce & vs & ~m_vs_prev;
      rsy = 1'b0;
      if (ce) begin
        m_age = hs ? (hr ? 1 : m_age + 1) : 0;
        m_hso = hs && (m_age >= 3) && (m_age <= 6);
        if (vr) begin
          m_fsr = 0; m_valive = 1'b1;
        end else begin
          if (!vs) m_valive = 1'b0;
          if (hf) begin m_fsr++; rsy = (m_fsr == 2); end
        end
        if (hr) m_mode = m_pend;
        m_hs_prev = hs; m_vs_prev = vs;
      end
      if (wr) m_pend = md;
      if (ack) begin m_irq = 1'b0; m_cnt = m_cnt % 32; end
      if (hf) begin
        if (rsy) begin
          if (m_cnt >= 32) m_irq = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == 52) begin m_cnt = 0; m_irq = 1'b1; end
        end
      end
      if (clr) begin m_cnt = 0; m_irq = 1'b0; end
    end
    exp_q.push_back({m_hso, (m_valive && m_fsr >= 2 && m_fsr < 6), ~m_irq, m_mode, 6'(m_cnt)});
  endtask

  task automatic step(input logic ce, hs, vs, ack, clr, wr, input logic [1:0] md);
    logic [10:0] e;
    @(negedge CLOCK);
    CLKEN = ce; CRTC_HSYNC = hs; CRTC_VSYNC = vs;
    INT_ACK = ack; IRQ_CLR = clr; MODE_WR = wr; MODE_IN = md;
    @(posedge CLOCK);
    model(ce, hs, vs, ack, clr, wr, md);
    #1;
    e = exp_q.pop_front();
    check("hsync_o", 8'(HSYNC_O), 8'(e[10]));
    check("vsync_o", 8'(VSYNC_O), 8'(e[9]));
    check("int_n",   8'(INT_N),   8'(e[8]));
    check("mode",    8'(MODE),    8'(e[7:6]));
    check("irq_cnt", 8'(IRQ_CNT), 8'(e[5:0]));
  endtask

  logic rand_pulses = 1'b0;

  task automatic char_ev(input logic hs, vs, ack, clr, wr, input logic [1:0] md);
    logic a, c, w;
    logic [1:0] m;
    a = ack; c = clr; w = wr; m = md;
    if (rand_pulses) begin
      a = a | ($urandom_range(0, 15) == 0);
      c = c | ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin w = 1'b1; m = 2'($urandom_range(0, 3)); end
    end
    step(1'b1, hs, vs, a, c, w, m);
    repeat ($urandom_range(0, 2)) step(1'b0, hs, vs, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  int hs_hi_cnt, hs_first;

  // One scanline: hi chars of HSYNC, then lo chars low; the first low char carries the fall pulses.
  task automatic line_ev(input int hi, input int lo, input logic vs, input logic ack, input logic clr);
    hs_hi_cnt = 0; hs_first = -1;
    for (int i = 0; i < hi; i++) begin
      char_ev(1'b1, vs, 1'b0, 1'b0, 1'b0, 2'd0);
      if (HSYNC_O) begin
        hs_hi_cnt++;
        if (hs_first < 0) hs_first = i;
      end
    end
    char_ev(1'b0, vs, ack, clr, 1'b0, 2'd0);
    for (int i = 1; i < lo; i++) char_ev(1'b0, vs, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic rline(input logic vs);
    line_ev($urandom_range(1, 8), $urandom_range(2, 5), vs, 1'b0, 1'b0);
  endtask

  initial begin
    int vs_hi, vs_first, vs_run;
    logic vs_lvl;
    nRESET = 1'b0; CLKEN = 1'b0; CRTC_HSYNC = 1'b0; CRTC_VSYNC = 1'b0;
    INT_ACK = 1'b0; IRQ_CLR = 1'b0; MODE_WR = 1'b0; MODE_IN = 2'd0;

    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    check("rst_hsync", 8'(HSYNC_O), 8'd0);
    check("rst_vsync", 8'(VSYNC_O), 8'd0);
    check("rst_int_n", 8'(INT_N), 8'd1);
    check("rst_mode", 8'(MODE), 8'd0);
    check("rst_cnt", 8'(IRQ_CNT), 8'd0);
    nRESET = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Monitor HSYNC width and truncation
    line_ev(14, 3, 1'b0, 1'b0, 1'b0);
    check("hs14_width", 8'(hs_hi_cnt), 8'd4);
    check("hs14_first", 8'(hs_first), 8'd2);
    line_ev(3, 4, 1'b0, 1'b0, 1'b0);
    check("hs3_width", 8'(hs_hi_cnt), 8'd1);
    check("hs3_first", 8'(hs_first), 8'd2);

    // R52 interrupt every 52 lines, acknowledge
    repeat (50) rline(1'b0);
    check("irq52_int_n", 8'(INT_N), 8'd0);
    check("irq52_cnt", 8'(IRQ_CNT), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    check("ack_int_n", 8'(INT_N), 8'd1);
    check("ack_cnt", 8'(IRQ_CNT), 8'd0);
    repeat (51) rline(1'b0);
    check("irq51_int_n", 8'(INT_N), 8'd1);
    check("irq51_cnt", 8'(IRQ_CNT), 8'd51);
    rline(1'b0);
    check("irq104_int_n", 8'(INT_N), 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // VSYNC resync with cnt at 40, then at 20
    repeat (40) rline(1'b0);
    check("pre_rs40_cnt", 8'(IRQ_CNT), 8'd40);
    rline(1'b1);
    rline(1'b1);
    check("rs40_int_n", 8'(INT_N), 8'd0);
    check("rs40_cnt", 8'(IRQ_CNT), 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    repeat (20) rline(1'b0);
    check("pre_rs20_cnt", 8'(IRQ_CNT), 8'd20);
    rline(1'b1);
    rline(1'b1);
    check("rs20_int_n", 8'(INT_N), 8'd1);
    check("rs20_cnt", 8'(IRQ_CNT), 8'd0);
    repeat (2) rline(1'b0);

    // CLR colliding with the 52nd fall; ACK clears cnt[5]
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    check("clr_cnt", 8'(IRQ_CNT), 8'd0);
    repeat (51) rline(1'b0);
    line_ev(4, 3, 1'b0, 1'b0, 1'b1);
    check("clr52_int_n", 8'(INT_N), 8'd1);
    check("clr52_cnt", 8'(IRQ_CNT), 8'd0);
    repeat (45) rline(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    check("ack45_cnt", 8'(IRQ_CNT), 8'd13);
    check("ack45_int_n", 8'(INT_N), 8'd1);
    repeat (38) rline(1'b0);
    line_ev(4, 3, 1'b0, 1'b1, 1'b0);
    check("ackfall51_cnt", 8'(IRQ_CNT), 8'd20);
    check("ackfall51_int_n", 8'(INT_N), 8'd1);

    // Monitor VSYNC over a 16-line CRTC VSYNC
    vs_hi = 0; vs_first = -1;
    for (int l = 0; l < 16; l++) begin
      rline(1'b1);
      if (VSYNC_O) begin
        vs_hi++;
        if (vs_first < 0) vs_first = l;
      end
    end
    check("vs16_width", 8'(vs_hi), 8'd4);
    check("vs16_first", 8'(vs_first), 8'd1);
    repeat (2) rline(1'b0);

    // Mode latch on HSYNC rise
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    check("mode_pend", 8'(MODE), 8'd0);
    rline(1'b0);
    check("mode_hs", 8'(MODE), 8'd2);
    char_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    check("mode_coinc", 8'(MODE), 8'd2);
    line_ev(3, 3, 1'b0, 1'b0, 1'b0);
    check("mode_coinc_hold", 8'(MODE), 8'd2);
    rline(1'b0);
    check("mode_next", 8'(MODE), 8'd3);

    // Randomized frames with sprinkled pulses and one mid-frame reset
    rand_pulses = 1'b1;
    vs_lvl = 1'b0; vs_run = 5;
    for (int l = 0; l < 300; l++) begin
      if (vs_run == 0) begin
        vs_lvl = ~vs_lvl;
        vs_run = vs_lvl ? $urandom_range(1, 18) : $urandom_range(4, 40);
      end
      vs_run--;
      if (l == 150) begin
        nRESET = 1'b0;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        nRESET = 1'b1;
        vs_lvl = 1'b1; vs_run = 8;
      end
      rline(vs_lvl);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
